// File: rtl/sync_frame_serializer_fsm.sv
// rtl/sync_frame_serializer_fsm.sv - serial frame transmitter: sync word, payload MSB first, even parity, idle gap
module sync_frame_serializer_fsm #(
    parameter int                  WIDTH    = 8,
    parameter int                  SYNC_LEN = 6,
    parameter logic [SYNC_LEN-1:0] SYNC     = 6'b110011,
    parameter int                  GAP      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] data,
    output logic             a_out,
    output logic             a_valid,
    output logic             busy,
    output logic             done
);

    localparam int MAX_SW = (SYNC_LEN > WIDTH) ? SYNC_LEN : WIDTH;
    localparam int MAX_L  = (MAX_SW > GAP) ? MAX_SW : GAP;
    localparam int CW     = $clog2(MAX_L) + 1;

    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_PAR,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic              par_q, par_d;
    logic              a_out_q, a_out_d;
    logic              a_valid_q, a_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SYNC_LEN-1:0] sync_sh;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        par_d   = par_q;

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    state_d = S_SYNC;
                    cnt_d   = '0;
                    sh_d    = data;
                    par_d   = ^data;
                end
            end
            S_SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = S_PAR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    sh_d  = sh_q << 1;
                end
            end
            S_PAR: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so derive them from the state being entered.
        sync_sh   = SYNC << cnt_d;
        a_out_d   = 1'b0;
        a_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_d)
            S_SYNC: begin
                a_valid_d = 1'b1;
                busy_d    = 1'b1;
                a_out_d   = sync_sh[SYNC_LEN-1];
            end
            S_DATA: begin
                a_valid_d = 1'b1;
                busy_d    = 1'b1;
                a_out_d   = sh_d[WIDTH-1];
            end
            S_PAR: begin
                a_valid_d = 1'b1;
                busy_d    = 1'b1;
                a_out_d   = par_d;
            end
            S_GAP: begin
                busy_d = 1'b1;
                done_d = (state_q != S_GAP);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
            a_out_q   <= 1'b0;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            par_q     <= par_d;
            a_out_q   <= a_out_d;
            a_valid_q <= a_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign a_out       = a_out_q;
    assign a_valid     = a_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
